// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line and received-byte signals between uart_rx and its consumer
// master (uart_rx): rx in; data_out, data_valid, frame_err, busy out
// slave (consumer): the mirror image
interface uart_rx_if;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;
  modport master(input rx, output data_out, data_valid, frame_err, busy);
  modport slave(output rx, input data_out, data_valid, frame_err, busy);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with start validation, centre sampling and framing check
// clk/rst: system clock, asynchronous active-high reset
// bus.rx: raw serial line; bus.data_out: last good byte; bus.data_valid/bus.frame_err: one-cycle strobes
// bus.busy: high while a frame is in progress
// UART_RX_MAJORITY_EN: 2-of-3 vote over counts T-2..T at every sample point
module uart_rx #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 9600
) (
  input logic clk,
  input logic rst,
  uart_rx_if.master bus
);
  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam logic [15:0] BIT_T = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_T = 16'(HALF_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP} state_t;
  state_t state, state_n;
  logic rx_m, rx_s, smp, valid_n, err_n;
  logic [15:0] clk_count, count_n;
  logic [2:0] bit_index, index_n;
  logic [7:0] shift, shift_n, data_n;
`ifdef UART_RX_MAJORITY_EN
  // counts advance every cycle, so the last two rx_s values are the T-2 and T-1 samples
  logic [1:0] hist;
  always_ff @(posedge clk or posedge rst)
    if (rst) hist <= 2'b11;
    else hist <= {hist[0], rx_s};
  assign smp = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  assign smp = rx_s;
`endif
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      state <= IDLE;
      clk_count <= '0;
      bit_index <= '0;
      shift <= '0;
      bus.data_out <= '0;
      bus.data_valid <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      rx_m <= bus.rx;
      rx_s <= rx_m;
      state <= state_n;
      clk_count <= count_n;
      bit_index <= index_n;
      shift <= shift_n;
      bus.data_out <= data_n;
      bus.data_valid <= valid_n;
      bus.frame_err <= err_n;
    end
  always_comb begin
    state_n = state;
    count_n = clk_count + 16'd1;
    index_n = bit_index;
    shift_n = shift;
    data_n = bus.data_out;
    valid_n = 1'b0;
    err_n = 1'b0;
    case (state)
      IDLE: begin
        count_n = '0;
        index_n = '0;
        state_n = rx_s ? IDLE : START;
      end
      START:
        if (clk_count == HALF_T) begin
          count_n = '0;
          state_n = smp ? IDLE : DATA;
        end
      DATA:
        if (clk_count == BIT_T) begin
          count_n = '0;
          shift_n[bit_index] = smp;
          index_n = bit_index + 3'd1;
          state_n = bit_index == 3'd7 ? STOP : DATA;
        end
      STOP:
        if (clk_count == BIT_T) begin
          count_n = '0;
          state_n = CLEANUP;
          valid_n = smp;
          err_n = ~smp;
          data_n = smp ? shift : bus.data_out;
        end
      CLEANUP: begin
        count_n = '0;
        state_n = rx_s ? IDLE : CLEANUP;
      end
      default: begin
        count_n = '0;
        index_n = '0;
        state_n = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx with 16-cycle bits
module tb_uart_rx;
  typedef struct {logic err; logic [7:0] d; int gap;} exp_t;
  logic clk = 1'b0, rst = 1'b1;
  int vectors = 0, miscompares = 0, cyc = 0, last_cyc = 0;
  exp_t sb[$];
  uart_rx_if bus();
  uart_rx #(.CLOCK_FREQ(160), .BAUD_RATE(10)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic send(input logic [7:0] d, input logic stop, input int gbit, input int ncyc);
    logic [9:0] f = {stop, d, 1'b0};
    int n = 0;
    for (int b = 0; b < 10; b++)
      for (int c = 0; c < 16; c++)
        if (n < ncyc) begin
          bus.rx = (b == gbit && c == 8) ? ~f[b] : f[b];
          n++;
          @(negedge clk);
        end
  endtask
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (bus.data_valid || bus.frame_err) begin
      if (sb.size() == 0) check("unexpected_strobe", {bus.data_valid, bus.frame_err}, 0);
      else begin
        e = sb.pop_front();
        check("strobe_kind", {bus.data_valid, bus.frame_err}, e.err ? 2'b01 : 2'b10);
        check("data_out", bus.data_out, e.d);
        if (e.gap != 0) check("strobe_gap", cyc - last_cyc, e.gap);
      end
      last_cyc = cyc;
    end
  end
  initial begin
    int bc;
    bus.rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", bus.data_out, 0);
    check("rst_valid", bus.data_valid, 0);
    check("rst_err", bus.frame_err, 0);
    check("rst_busy", bus.busy, 0);
    @(negedge clk) rst = 1'b0;
    repeat (5) @(negedge clk);
    sb.push_back('{1'b0, 8'hA5, 0});
    fork
      send(8'hA5, 1'b1, -1, 160);
      begin
        repeat (2) @(posedge clk);
        #1 check("busy_edge2", bus.busy, 0);
        @(posedge clk);
        #1 check("busy_edge3", bus.busy, 1);
        repeat (152) @(posedge clk);
        #1 check("valid_edge155", bus.data_valid, 1);
        check("busy_at_strobe", bus.busy, 1);
        @(posedge clk);
        #1 check("busy_fall", bus.busy, 0);
      end
    join
    repeat (10) @(negedge clk);
    sb.push_back('{1'b0, 8'h00, 0});
    sb.push_back('{1'b0, 8'hFF, 160});
    sb.push_back('{1'b0, 8'h3C, 160});
    send(8'h00, 1'b1, -1, 160);
    send(8'hFF, 1'b1, -1, 160);
    send(8'h3C, 1'b1, -1, 160);
    repeat (10) @(negedge clk);
    sb.push_back('{1'b1, 8'h3C, 0});
    send(8'h12, 1'b0, -1, 160);
    bus.rx = 1'b0;
    repeat (40) @(negedge clk);
    check("busy_stuck_low", bus.busy, 1);
    bus.rx = 1'b1;
    repeat (20) @(negedge clk);
    check("busy_after_release", bus.busy, 0);
    bc = 0;
    fork
      begin
        bus.rx = 1'b0;
        repeat (3) @(negedge clk);
        bus.rx = 1'b1;
      end
      repeat (20) begin
        @(posedge clk);
        #1 bc += int'(bus.busy);
      end
    join
    check("glitch_busy_cycles", bc, 8);
    repeat (5) @(negedge clk);
    send(8'h5A, 1'b1, -1, 88);
    rst = 1'b1;
    #1;
    check("midrst_data_out", bus.data_out, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_valid", bus.data_valid, 0);
    check("midrst_err", bus.frame_err, 0);
    bus.rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    sb.push_back('{1'b0, 8'h81, 0});
    send(8'h81, 1'b1, -1, 160);
    repeat (10) @(negedge clk);
`ifdef UART_RX_MAJORITY_EN
    sb.push_back('{1'b0, 8'h0F, 0});
`else
    sb.push_back('{1'b0, 8'h0B, 0});
`endif
    send(8'h0F, 1'b1, 3, 160);
    repeat (20) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
